// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase fetch/execute control sequencer for the 8-bit RISC CPU.
// A 3-bit phase counter steps through fetch (0-3) and execute (4-7); all memory,
// mux and load strobes are combinational decodes of phase, halted flag, opcode, zero.
module cpu_sequencer #(
  parameter int HALT_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic HOLD_EN = (HALT_HOLD != 0);

  logic [2:0] r_phase;
  logic       r_halted;

  logic       w_aluop;
  logic       w_is_hlt;
  logic       w_enter_halt;

  assign w_aluop      = (opcode == OP_ADD) || (opcode == OP_AND) ||
                        (opcode == OP_XOR) || (opcode == OP_LDA);
  assign w_is_hlt     = (opcode == OP_HLT);
  // A held halt is entered from phase 4 and keeps the counter parked there.
  assign w_enter_halt = HOLD_EN && (r_phase == 3'd4) && w_is_hlt;

  // Phase counter and sticky halted flag; only reset leaves the halted state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase  <= 3'd0;
      r_halted <= 1'b0;
    end else if (r_halted) begin
      r_phase  <= r_phase;
      r_halted <= 1'b1;
    end else if (w_enter_halt) begin
      r_phase  <= r_phase;
      r_halted <= 1'b1;
    end else begin
      r_phase  <= r_phase + 3'd1;
    end
  end

  // Strobe decode; reset forces everything low so no write can slip out.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    phase  = 3'd0;
    if (rst_n) begin
      phase = r_phase;
      if (r_halted) begin
        halt = 1'b1;
      end else begin
        case (r_phase)
          3'd0: sel = 1'b1;
          3'd1: begin
            sel = 1'b1;
            rd  = 1'b1;
          end
          3'd2, 3'd3: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
          end
          3'd4: begin
            halt   = w_is_hlt;
            inc_pc = !w_is_hlt;
          end
          3'd5: rd = w_aluop;
          3'd6: begin
            rd     = w_aluop;
            inc_pc = (opcode == OP_SKZ) && zero;
            ld_pc  = (opcode == OP_JMP);
            data_e = (opcode == OP_STO);
          end
          default: begin
            rd     = w_aluop;
            ld_ac  = w_aluop;
            ld_pc  = (opcode == OP_JMP);
            wr     = (opcode == OP_STO);
            data_e = (opcode == OP_STO);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised plus directed bench for cpu_sequencer; two instances (held and
// pulsed halt) run against a phase/halt model derived from the opcode rules.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;

  logic       sel_a, rd_a, wr_a, ld_ir_a, ld_ac_a, inc_pc_a, ld_pc_a, data_e_a, halt_a;
  logic [2:0] phase_a;
  logic       sel_b, rd_b, wr_b, ld_ir_b, ld_ac_b, inc_pc_b, ld_pc_b, data_e_b, halt_b;
  logic [2:0] phase_b;

  int n_checks = 0;
  int n_fail   = 0;

  int m_ph [2];
  bit m_h  [2];
  int hold_cnt = 0;

  cpu_sequencer #(.HALT_HOLD(1)) dut_hold (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel_a), .rd(rd_a), .wr(wr_a), .ld_ir(ld_ir_a), .ld_ac(ld_ac_a),
    .inc_pc(inc_pc_a), .ld_pc(ld_pc_a), .data_e(data_e_a), .halt(halt_a),
    .phase(phase_a)
  );

  cpu_sequencer #(.HALT_HOLD(0)) dut_pulse (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel_b), .rd(rd_b), .wr(wr_b), .ld_ir(ld_ir_b), .ld_ac(ld_ac_b),
    .inc_pc(inc_pc_b), .ld_pc(ld_pc_b), .data_e(data_e_b), .halt(halt_b),
    .phase(phase_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt,phase[2:0]}.
  function automatic logic [11:0] exp_out(input int ph, input bit h, input logic rn,
                                          input logic [2:0] opc, input logic z);
    bit alu, s, r, w, li, la, ip, lp, de, ht;
    alu = (opc >= 3'd2) && (opc <= 3'd5);
    if (!rn) return 12'd0;
    if (h) return {9'b0_0000_0001, 3'(ph)};
    s  = (ph < 4);
    r  = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
    li = (ph == 2 || ph == 3);
    ht = (ph == 4) && (opc == 3'd0);
    ip = ((ph == 4) && (opc != 3'd0)) || ((ph == 6) && (opc == 3'd1) && z);
    lp = (opc == 3'd7) && (ph >= 6);
    de = (opc == 3'd6) && (ph >= 6);
    w  = (opc == 3'd6) && (ph == 7);
    la = alu && (ph == 7);
    return {s, r, w, li, la, ip, lp, de, ht, 3'(ph)};
  endfunction

  // One clock: drive inputs, compare both instances mid-cycle, advance the model.
  task automatic cycle(input logic [2:0] opc, input logic z, input logic rn);
    logic [11:0] e;
    opcode = opc;
    zero   = z;
    rst_n  = rn;
    @(negedge clk);
    e = exp_out(m_ph[0], m_h[0], rn, opc, z);
    check_val("hold_strobes", {23'd0, sel_a, rd_a, wr_a, ld_ir_a, ld_ac_a, inc_pc_a,
              ld_pc_a, data_e_a, halt_a}, {23'd0, e[11:3]});
    check_val("hold_phase", {29'd0, phase_a}, {29'd0, e[2:0]});
    e = exp_out(m_ph[1], m_h[1], rn, opc, z);
    check_val("pulse_strobes", {23'd0, sel_b, rd_b, wr_b, ld_ir_b, ld_ac_b, inc_pc_b,
              ld_pc_b, data_e_b, halt_b}, {23'd0, e[11:3]});
    check_val("pulse_phase", {29'd0, phase_b}, {29'd0, e[2:0]});
    check_val("rd_wr_excl", {30'd0, rd_a & wr_a, rd_b & wr_b}, 32'd0);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        m_ph[k] = 0;
        m_h[k]  = 1'b0;
      end else if (m_h[k]) begin
        m_ph[k] = m_ph[k];
      end else if (k == 0 && m_ph[k] == 4 && opc == 3'd0) begin
        m_h[k] = 1'b1;
      end else begin
        m_ph[k] = (m_ph[k] + 1) % 8;
      end
    end
    #1;
  endtask

  task automatic run_instr(input logic [2:0] opc, input logic z, input string name);
    for (int p = 0; p < 8; p++) cycle(opc, z, 1'b1);
    $display("instr %s zero=%0d done, phase now %0d", name, z, phase_a);
  endtask

  initial begin
    logic [2:0] opc;
    logic       rn;
    m_ph[0] = 0; m_ph[1] = 0;
    m_h[0]  = 1'b0; m_h[1] = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    rst_n  = 1'b0;

    cycle(3'd2, 1'b0, 1'b0);
    cycle(3'd2, 1'b0, 1'b0);
    $display("reset applied");

    run_instr(3'd2, 1'b0, "ADD");
    run_instr(3'd6, 1'b0, "STO");
    run_instr(3'd1, 1'b1, "SKZ");
    run_instr(3'd1, 1'b0, "SKZ");
    run_instr(3'd7, 1'b1, "JMP");
    run_instr(3'd3, 1'b1, "AND");
    run_instr(3'd4, 1'b0, "XOR");
    run_instr(3'd5, 1'b0, "LDA");

    // HLT: held instance parks in phase 4, pulsed one keeps running.
    for (int p = 0; p < 5; p++) cycle(3'd0, 1'b0, 1'b1);
    for (int p = 0; p < 22; p++) cycle(3'd2, 1'b1, 1'b1);
    check_val("halt_parked_phase", {29'd0, phase_a}, 32'd4);
    check_val("halt_parked_flag", {31'd0, halt_a}, 32'd1);
    $display("HLT held 22 cycles, phase=%0d halt=%0d", phase_a, halt_a);
    cycle(3'd2, 1'b0, 1'b0);
    check_val("halt_cleared", {28'd0, halt_a, phase_a}, 32'd0);
    $display("reset after HLT, phase=%0d halt=%0d", phase_a, halt_a);

    // Reset landing on phase 7 of a store.
    for (int p = 0; p < 7; p++) cycle(3'd6, 1'b0, 1'b1);
    cycle(3'd6, 1'b0, 1'b0);
    check_val("sto_reset_phase", {29'd0, phase_a}, 32'd0);
    $display("reset in STO phase 7, phase=%0d", phase_a);

    // Randomised run; opcode only changes at the start of a fetch.
    opc = 3'd2;
    for (int n = 0; n < 800; n++) begin
      if (m_h[0]) hold_cnt++;
      rn = !(hold_cnt > 24 || $urandom_range(0, 59) == 0);
      if (!rn) hold_cnt = 0;
      if (m_ph[0] == 0 && !m_h[0]) opc = 3'($urandom_range(0, 7));
      cycle(opc, 1'($urandom_range(0, 1)), rn);
    end
    $display("random run of 800 cycles complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Eight-phase control sequencer for the 8-bit RISC CPU.
- Steps a phase counter through fetch and execute for every instruction.
- Decodes the 3-bit opcode from the instruction register, plus the accumulator zero flag.
- Drives the 32x8 synchronous-read memory (`rd`, `wr`), the address mux select, and the IR/PC/accumulator load and enable strobes.
- Sits directly upstream of the memory: it is the only source of that memory's `rd` and `wr`.

## Interface
Parameters:
- `HALT_HOLD`, default 1. When 1, a HLT instruction freezes the sequencer until reset. When 0, HLT only pulses `halt` for one cycle and execution continues.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `opcode`  in  3  instruction register opcode (bits [7:5] of IR).
- `zero`  in  1  accumulator-is-zero flag.
- `sel`  out  1  address mux select: 1 = PC, 0 = IR operand field.
- `rd`  out  1  memory read enable.
- `wr`  out  1  memory write enable.
- `ld_ir`  out  1  load instruction register from memory `data_out`.
- `ld_ac`  out  1  load accumulator from ALU.
- `inc_pc`  out  1  increment program counter.
- `ld_pc`  out  1  load PC from the IR operand field.
- `data_e`  out  1  drive accumulator onto the memory `data_in` bus.
- `halt`  out  1  CPU halted.
- `phase`  out  3  current phase, for debug.

## Operation
- Opcode map: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- ALUOP = ADD, AND, XOR or LDA.
- Phase register `phase` counts 0→7 and wraps 7→0. It advances by 1 every cycle unless reset or halted.
- Phases 0-3 (fetch):
  - `sel`=1 in phases 0-3.
  - `rd`=1 in phases 1-3.
  - `ld_ir`=1 in phases 2-3.
- Phases 4-7 (execute), with `sel`=0:
  - phase 4: if HLT, `halt`=1; otherwise `inc_pc`=1.
  - phase 5: `rd`=1 if ALUOP.
  - phase 6: `rd`=1 if ALUOP; `inc_pc`=1 if SKZ and `zero`=1; `ld_pc`=1 if JMP; `data_e`=1 if STO.
  - phase 7: `rd`=1 and `ld_ac`=1 if ALUOP; `ld_pc`=1 if JMP; `wr`=1 and `data_e`=1 if STO.
- Outputs are combinational decodes of `phase`, the halted flag, `opcode` and `zero`. Every output not listed as 1 is 0.
- `wr` and `rd` are never both 1 in the same cycle.
- Halt, `HALT_HOLD`=1:
  - Phase 4 with HLT sets the halted flag at the next edge.
  - While halted: `phase` holds 4, `halt`=1, and all other outputs are 0 regardless of `opcode`.
  - Only reset clears the halted flag.
- Halt, `HALT_HOLD`=0: `halt` is 1 for the phase-4 cycle only, and the phase advances normally.

## Timing
- Reset: `rst_n`=0 sampled at an edge sets `phase`=0 and clears the halted flag.
- While `rst_n`=0, all outputs are forced to 0, including `sel`, and `phase` reads 0.
- Reset asserted mid-instruction, in any phase or while halted: the next edge returns the block to phase 0. Nothing is written after that edge.
- First cycle after `rst_n` rises: phase 0, `sel`=1, all other strobes 0.
- Memory read latency is 1 cycle:
  - `rd` in phase 1 puts valid `data_out` in phase 2.
  - `ld_ir` in phases 2-3 captures it.
  - `opcode` must be stable from phase 4 through phase 7.
- Operand read: `rd` from phase 5 puts data valid in phase 6; `ld_ac` in phase 7 captures the ALU result.
- `zero` is sampled only in phase 6.
- One instruction takes 8 cycles. There is no stall or wait input.

## Test plan
- Reset, then 8 cycles with `opcode`=2 (ADD) → `phase` runs 0..7, then 0.
  - `rd` high in phases 1,2,3,5,6,7.
  - `ld_ir` high in phases 2-3.
  - `inc_pc` high in phase 4 only.
  - `ld_ac` high in phase 7.
  - `wr` never high.
- `opcode`=6 (STO) → `data_e` high in phases 6-7; `wr` high in phase 7 only; `rd` low in phases 5-7.
- `opcode`=1 (SKZ):
  - with `zero`=1 → `inc_pc` high in phases 4 and 6.
  - with `zero`=0 → `inc_pc` high in phase 4 only.
- `opcode`=7 (JMP) → `ld_pc` high in phases 6-7; `inc_pc` high in phase 4; `rd` low in phases 5-7.
- `opcode`=0 (HLT), `HALT_HOLD`=1:
  - `halt` rises in phase 4, and `phase` stays 4 for 20+ cycles with all strobes 0, even if `opcode` changes to 2.
  - Then `rst_n`=0 for 1 cycle → `phase`=0, `halt`=0.
- Reset asserted in phase 7 of STO → `wr` is 0 while reset is low; `phase`=0 after the edge. With `HALT_HOLD`=0 and HLT, `halt` pulses for 1 cycle and `phase` reaches 5.
